// File: rtl/cluster_centroid_pkg.sv
// Shared types and widths for the cluster centroid block.
package cluster_centroid_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CH_W     = 9;
  localparam int SUM_W    = 32;
  localparam int WSUM_W   = 40;
  localparam int POS_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WAIT_CL,
    ST_ACCUM,
    ST_DIVIDE,
    ST_OUTPUT
  } state_t;

  // Charge can only add to a cluster; negative (pedestal-undershoot) samples count as zero.
  function automatic logic [SAMPLE_W-1:0] clamp_sample(input logic [SAMPLE_W-1:0] s);
    return s[SAMPLE_W-1] ? '0 : s;
  endfunction

endpackage

// File: rtl/cluster_centroid_div.sv
// Serial restoring divider: one quotient bit per cycle, fixed QUOT_W-cycle latency after start.
// The caller guarantees the quotient fits in QUOT_W bits (dividend < divisor << QUOT_W).
module cluster_centroid_div
  import cluster_centroid_pkg::*;
#(
  parameter int DIVIDEND_W = WSUM_W + 7,
  parameter int DIVISOR_W  = SUM_W,
  parameter int QUOT_W     = POS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [QUOT_W-1:0]     quotient,
  output logic                  done
);

  localparam int REM_W = DIVISOR_W + 1;
  localparam int CNT_W = $clog2(QUOT_W + 1);

  logic [DIVISOR_W-1:0] rem;
  logic [DIVISOR_W-1:0] rem_nxt;
  logic [DIVISOR_W-1:0] div_q;
  logic [REM_W-1:0]     trial;
  logic [QUOT_W-1:0]    shift_q;
  logic [CNT_W-1:0]     count;
  logic                 fits;

  // The upper dividend bits are already below the divisor, so they seed the remainder
  // and only the low QUOT_W bits need to be shifted through.
  always_comb begin
    trial   = {rem, shift_q[QUOT_W-1]};
    fits    = trial >= {1'b0, div_q};
    rem_nxt = fits ? DIVISOR_W'(trial - {1'b0, div_q}) : trial[DIVISOR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem     <= '0;
      div_q   <= '0;
      shift_q <= '0;
      count   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem     <= DIVISOR_W'(dividend[DIVIDEND_W-1:QUOT_W]);
        shift_q <= dividend[QUOT_W-1:0];
        div_q   <= divisor;
        count   <= CNT_W'(QUOT_W);
      end else if (count != '0) begin
        rem     <= rem_nxt;
        shift_q <= {shift_q[QUOT_W-2:0], fits};
        count   <= count - CNT_W'(1);
        done    <= (count == CNT_W'(1));
      end
    end
  end

  assign quotient = shift_q;

endmodule

// File: rtl/cluster_centroid.sv
// Buffers one frame of channel samples, then computes the charge-weighted centroid and
// summed amplitude of the locator's cluster. Optional peak outputs: CLUSTER_CENTROID_PEAK_EN.
module cluster_centroid
  import cluster_centroid_pkg::*;
#(
  parameter int N_CH       = 320,
  parameter int HDR_WORDS  = 6,
  parameter int FRAC_BITS  = 7,
  parameter int CL_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] data_in_data,
  input  logic                data_in_valid,
  input  logic                data_in_startofpacket,
  input  logic                data_in_endofpacket,
  input  logic [1:0]          data_in_empty,
  input  logic [CH_W-1:0]     cl_ch_left,
  input  logic [CH_W-1:0]     cl_ch_right,
  input  logic                cl_has_cluster,
  input  logic                cl_no_cluster,
  output logic [POS_W-1:0]    pos_data,
  output logic [SUM_W-1:0]    sum_data,
  output logic                result_valid,
  output logic                result_no_cluster,
  output logic                result_timeout,
  output logic                busy,
  output logic [15:0]         drop_cnt
`ifdef CLUSTER_CENTROID_PEAK_EN
  ,
  output logic [CH_W-1:0]     peak_ch,
  output logic [SAMPLE_W-1:0] peak_amp
`endif
);

  localparam int CHX_W      = CH_W + 1;
  localparam int CNT_W      = $clog2(HDR_WORDS + N_CH + 1);
  localparam int TMO_W      = $clog2(CL_TIMEOUT + 1);
  localparam int DIVIDEND_W = WSUM_W + FRAC_BITS;
  localparam int PROD_W     = CH_W + SAMPLE_W;

  state_t state, next_state;

  logic [CNT_W-1:0]    word_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [CH_W-1:0]     right_q;
  logic [CHX_W-1:0]    rd_ch;
  logic [CH_W-1:0]     data_ch;
  logic                data_vld;
  logic [SUM_W-1:0]    sum_acc;
  logic [WSUM_W-1:0]   wsum_acc;
  logic                div_issued;

  logic [SAMPLE_W-1:0] mem [0:N_CH-1];
  logic [SAMPLE_W-1:0] rd_data;
  logic [CH_W-1:0]     wr_addr;
  logic [CH_W-1:0]     mem_addr;
  logic                mem_we;
  logic                rd_issue;

  logic                sop_word;
  logic                capture_word;
  logic                in_window;
  logic                range_bad;
  logic                cl_accept;
  logic [SAMPLE_W-1:0] clamped;
  logic [PROD_W-1:0]   prod;

  logic                div_start;
  logic                div_done;
  logic [POS_W-1:0]    quotient;

  logic                out_load;
  logic [POS_W-1:0]    out_pos;
  logic [SUM_W-1:0]    out_sum;
  logic                out_nc;
  logic                out_to;

  logic                unused_empty;
  assign unused_empty = ^data_in_empty;

  assign sop_word     = data_in_valid && data_in_startofpacket;
  assign capture_word = (state == ST_CAPTURE) && data_in_valid && !data_in_startofpacket;
  assign in_window    = (word_cnt >= CNT_W'(HDR_WORDS)) && (word_cnt < CNT_W'(HDR_WORDS + N_CH));
  assign mem_we       = capture_word && in_window;
  assign wr_addr      = CH_W'(word_cnt - CNT_W'(HDR_WORDS));
  assign rd_issue     = (state == ST_ACCUM) && (rd_ch <= {1'b0, right_q});
  assign mem_addr     = (state == ST_ACCUM) ? rd_ch[CH_W-1:0] : wr_addr;
  assign range_bad    = (cl_ch_left > cl_ch_right) || ({1'b0, cl_ch_right} >= CHX_W'(N_CH));
  assign clamped      = clamp_sample(rd_data);
  assign prod         = {{SAMPLE_W{1'b0}}, data_ch} * {{CH_W{1'b0}}, clamped};
  assign busy         = (state != ST_IDLE);

  // Single-port frame buffer: written during capture, read back during accumulation.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= data_in_data;
    if (rd_issue) rd_data <= mem[mem_addr];
  end

`ifdef CLUSTER_CENTROID_PEAK_EN
  logic [CH_W-1:0]     peak_ch_acc;
  logic [SAMPLE_W-1:0] peak_amp_acc;
  logic [CH_W-1:0]     out_peak_ch;
  logic [SAMPLE_W-1:0] out_peak_amp;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    out_load   = 1'b0;
    out_pos    = '0;
    out_sum    = '0;
    out_nc     = 1'b0;
    out_to     = 1'b0;
    div_start  = 1'b0;
    cl_accept  = 1'b0;
`ifdef CLUSTER_CENTROID_PEAK_EN
    out_peak_ch  = '0;
    out_peak_amp = '0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (sop_word) next_state = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (data_in_valid && data_in_endofpacket) next_state = ST_WAIT_CL;
      end
      ST_WAIT_CL: begin
        if (cl_no_cluster || (cl_has_cluster && range_bad)) begin
          next_state = ST_OUTPUT;
          out_load   = 1'b1;
          out_nc     = 1'b1;
        end else if (cl_has_cluster) begin
          next_state = ST_ACCUM;
          cl_accept  = 1'b1;
        end else if (tmo_cnt == TMO_W'(CL_TIMEOUT - 1)) begin
          next_state = ST_OUTPUT;
          out_load   = 1'b1;
          out_to     = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (data_vld && (data_ch == right_q)) next_state = ST_DIVIDE;
      end
      ST_DIVIDE: begin
        // An all-zero cluster has no defined centroid, so it is reported as no cluster.
        if (!div_issued) begin
          if (sum_acc == '0) begin
            next_state = ST_OUTPUT;
            out_load   = 1'b1;
            out_nc     = 1'b1;
          end else begin
            div_start = 1'b1;
          end
        end else if (div_done) begin
          next_state = ST_OUTPUT;
          out_load   = 1'b1;
          out_pos    = quotient;
          out_sum    = sum_acc;
`ifdef CLUSTER_CENTROID_PEAK_EN
          out_peak_ch  = peak_ch_acc;
          out_peak_amp = peak_amp_acc;
`endif
        end
      end
      ST_OUTPUT: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Word index counts from the SOP word; a fresh SOP while capturing restarts the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (((state == ST_IDLE) || (state == ST_CAPTURE)) && sop_word)
        word_cnt <= CNT_W'(1);
      else if (capture_word && (word_cnt != CNT_W'(HDR_WORDS + N_CH)))
        word_cnt <= word_cnt + CNT_W'(1);
      tmo_cnt <= (state == ST_WAIT_CL) ? tmo_cnt + TMO_W'(1) : '0;
    end
  end

  // Read data lags the issued address by one cycle, so the channel tag travels with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      right_q    <= '0;
      rd_ch      <= '0;
      data_ch    <= '0;
      data_vld   <= 1'b0;
      sum_acc    <= '0;
      wsum_acc   <= '0;
      div_issued <= 1'b0;
    end else begin
      data_vld   <= rd_issue;
      data_ch    <= rd_ch[CH_W-1:0];
      div_issued <= (state == ST_DIVIDE) && (div_issued || div_start);
      if (cl_accept) begin
        right_q  <= cl_ch_right;
        rd_ch    <= {1'b0, cl_ch_left};
        sum_acc  <= '0;
        wsum_acc <= '0;
      end else if (state == ST_ACCUM) begin
        if (rd_issue) rd_ch <= rd_ch + CHX_W'(1);
        if (data_vld) begin
          sum_acc  <= sum_acc + SUM_W'(clamped);
          wsum_acc <= wsum_acc + WSUM_W'(prod);
        end
      end
    end
  end

`ifdef CLUSTER_CENTROID_PEAK_EN
  // Strictly-greater update while scanning upward keeps the lowest channel on ties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_ch_acc  <= '0;
      peak_amp_acc <= '0;
      peak_ch      <= '0;
      peak_amp     <= '0;
    end else begin
      if (cl_accept) begin
        peak_ch_acc  <= cl_ch_left;
        peak_amp_acc <= '0;
      end else if ((state == ST_ACCUM) && data_vld && (clamped > peak_amp_acc)) begin
        peak_ch_acc  <= data_ch;
        peak_amp_acc <= clamped;
      end
      if (out_load) begin
        peak_ch  <= out_peak_ch;
        peak_amp <= out_peak_amp;
      end
    end
  end
`endif

  cluster_centroid_div #(
    .DIVIDEND_W (DIVIDEND_W),
    .DIVISOR_W  (SUM_W),
    .QUOT_W     (POS_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend ({wsum_acc, {FRAC_BITS{1'b0}}}),
    .divisor  (sum_acc),
    .quotient (quotient),
    .done     (div_done)
  );

  // Result registers hold until the next record; drops count SOPs that arrive while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_data          <= '0;
      sum_data          <= '0;
      result_valid      <= 1'b0;
      result_no_cluster <= 1'b0;
      result_timeout    <= 1'b0;
      drop_cnt          <= '0;
    end else begin
      result_valid <= out_load;
      if (out_load) begin
        pos_data          <= out_pos;
        sum_data          <= out_sum;
        result_no_cluster <= out_nc;
        result_timeout    <= out_to;
      end
      if (sop_word && (state inside {ST_WAIT_CL, ST_ACCUM, ST_DIVIDE, ST_OUTPUT}) &&
          (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cluster_centroid.sv
// Directed self-checking bench for cluster_centroid (peak outputs checked when
// CLUSTER_CENTROID_PEAK_EN is defined).
module tb_cluster_centroid;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in_data;
  logic        data_in_valid;
  logic        data_in_startofpacket;
  logic        data_in_endofpacket;
  logic [1:0]  data_in_empty;
  logic [8:0]  cl_ch_left;
  logic [8:0]  cl_ch_right;
  logic        cl_has_cluster;
  logic        cl_no_cluster;
  logic [15:0] pos_data;
  logic [31:0] sum_data;
  logic        result_valid;
  logic        result_no_cluster;
  logic        result_timeout;
  logic        busy;
  logic [15:0] drop_cnt;
`ifdef CLUSTER_CENTROID_PEAK_EN
  logic [8:0]  peak_ch;
  logic [15:0] peak_amp;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] frame [0:319];

  always #5 clk = ~clk;

  cluster_centroid dut (
    .clk                   (clk),
    .rst                   (rst),
    .data_in_data          (data_in_data),
    .data_in_valid         (data_in_valid),
    .data_in_startofpacket (data_in_startofpacket),
    .data_in_endofpacket   (data_in_endofpacket),
    .data_in_empty         (data_in_empty),
    .cl_ch_left            (cl_ch_left),
    .cl_ch_right           (cl_ch_right),
    .cl_has_cluster        (cl_has_cluster),
    .cl_no_cluster         (cl_no_cluster),
    .pos_data              (pos_data),
    .sum_data              (sum_data),
    .result_valid          (result_valid),
    .result_no_cluster     (result_no_cluster),
    .result_timeout        (result_timeout),
    .busy                  (busy),
    .drop_cnt              (drop_cnt)
`ifdef CLUSTER_CENTROID_PEAK_EN
    ,
    .peak_ch               (peak_ch),
    .peak_amp              (peak_amp)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frame;
    for (int i = 0; i < 320; i++) frame[i] = 16'h0000;
  endtask

  // SOP word, five header words, then 320 samples with EOP on the last one.
  task automatic send_frame;
    for (int i = 0; i < 326; i++) begin
      data_in_valid         = 1'b1;
      data_in_startofpacket = (i == 0);
      data_in_endofpacket   = (i == 325);
      if (i >= 6) data_in_data = frame[i-6];
      else        data_in_data = 16'h7ABC;
      tick();
    end
    data_in_valid         = 1'b0;
    data_in_startofpacket = 1'b0;
    data_in_endofpacket   = 1'b0;
    data_in_data          = 16'h0000;
  endtask

  task automatic pulse_locator(input logic [8:0] l, input logic [8:0] r,
                               input logic has, input logic no);
    cl_ch_left     = l;
    cl_ch_right    = r;
    cl_has_cluster = has;
    cl_no_cluster  = no;
    tick();
    cl_has_cluster = 1'b0;
    cl_no_cluster  = 1'b0;
  endtask

  task automatic wait_result(input int limit, output int cyc, output bit seen);
    cyc  = 0;
    seen = result_valid;
    while (!seen && cyc < limit) begin
      tick();
      cyc++;
      seen = result_valid;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (pos_data !== 16'd0) begin errors++; $display("[TB] FAIL reset_pos got %0d want 0", pos_data); end
    checks++; if (sum_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_sum got %0d want 0", sum_data); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", result_valid); end
    checks++; if (result_no_cluster !== 1'b0 || result_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got nc=%b to=%b want 0 0", result_no_cluster, result_timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_drop got %0d want 0", drop_cnt); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_centroid;
    logic [8:0]  l, r, pk_ch;
    logic [15:0] exp_pos, pk_amp;
    logic [31:0] exp_sum;
    int cyc;
    bit seen;
    for (int v = 0; v < 5; v++) begin
      clear_frame();
      case (v)
        0: begin frame[100] = 16'd100; frame[101] = 16'd200; frame[102] = 16'd100;
                 l = 9'd100; r = 9'd102; exp_sum = 32'd400; exp_pos = 16'h3280; pk_ch = 9'd101; pk_amp = 16'd200; end
        1: begin frame[10] = 16'd100; frame[11] = 16'd300;
                 l = 9'd10; r = 9'd11; exp_sum = 32'd400; exp_pos = 16'd1376; pk_ch = 9'd11; pk_amp = 16'd300; end
        2: begin frame[5] = 16'hFFCE; frame[6] = 16'd100;
                 l = 9'd5; r = 9'd6; exp_sum = 32'd100; exp_pos = 16'd768; pk_ch = 9'd6; pk_amp = 16'd100; end
        3: begin frame[319] = 16'd50; frame[318] = 16'd999;
                 l = 9'd319; r = 9'd319; exp_sum = 32'd50; exp_pos = 16'd40832; pk_ch = 9'd319; pk_amp = 16'd50; end
        default: begin frame[0] = 16'd7; frame[1] = 16'd500;
                 l = 9'd0; r = 9'd0; exp_sum = 32'd7; exp_pos = 16'd0; pk_ch = 9'd0; pk_amp = 16'd7; end
      endcase
      send_frame();
      pulse_locator(l, r, 1'b1, 1'b0);
      wait_result(100, cyc, seen);
      checks++; if (!seen) begin errors++; $display("[TB] FAIL cen%0d_valid got none after %0d cycles want pulse", v, cyc); end
      checks++; if (cyc + 1 != int'(r) - int'(l) + 21) begin errors++; $display("[TB] FAIL cen%0d_latency got %0d want %0d", v, cyc + 1, int'(r) - int'(l) + 21); end
      checks++; if (pos_data !== exp_pos) begin errors++; $display("[TB] FAIL cen%0d_pos got %0d want %0d", v, pos_data, exp_pos); end
      checks++; if (sum_data !== exp_sum) begin errors++; $display("[TB] FAIL cen%0d_sum got %0d want %0d", v, sum_data, exp_sum); end
      checks++; if (result_no_cluster !== 1'b0 || result_timeout !== 1'b0) begin errors++; $display("[TB] FAIL cen%0d_flags got nc=%b to=%b want 0 0", v, result_no_cluster, result_timeout); end
`ifdef CLUSTER_CENTROID_PEAK_EN
      checks++; if (peak_ch !== pk_ch || peak_amp !== pk_amp) begin errors++; $display("[TB] FAIL cen%0d_peak got ch=%0d amp=%0d want ch=%0d amp=%0d", v, peak_ch, peak_amp, pk_ch, pk_amp); end
`endif
      tick();
      checks++; if (result_valid !== 1'b0 || pos_data !== exp_pos || busy !== 1'b0) begin errors++; $display("[TB] FAIL cen%0d_hold got valid=%b pos=%0d busy=%b want 0 %0d 0", v, result_valid, pos_data, busy, exp_pos); end
    end
  endtask

  task automatic test_no_cluster;
    logic [8:0] l, r;
    logic no;
    int cyc;
    bit seen;
    for (int v = 0; v < 3; v++) begin
      clear_frame();
      frame[100] = 16'd100; frame[101] = 16'd200; frame[102] = 16'd100;
      case (v)
        0: begin l = 9'd100; r = 9'd102; no = 1'b1; end
        1: begin l = 9'd200; r = 9'd100; no = 1'b0; end
        default: begin l = 9'd100; r = 9'd320; no = 1'b0; end
      endcase
      send_frame();
      pulse_locator(l, r, 1'b1, no);
      wait_result(50, cyc, seen);
      checks++; if (!seen || cyc != 0) begin errors++; $display("[TB] FAIL nc%0d_valid got seen=%b cyc=%0d want 1 0", v, seen, cyc); end
      checks++; if (result_no_cluster !== 1'b1 || result_timeout !== 1'b0) begin errors++; $display("[TB] FAIL nc%0d_flags got nc=%b to=%b want 1 0", v, result_no_cluster, result_timeout); end
      checks++; if (pos_data !== 16'd0 || sum_data !== 32'd0) begin errors++; $display("[TB] FAIL nc%0d_data got pos=%0d sum=%0d want 0 0", v, pos_data, sum_data); end
`ifdef CLUSTER_CENTROID_PEAK_EN
      checks++; if (peak_ch !== 9'd0 || peak_amp !== 16'd0) begin errors++; $display("[TB] FAIL nc%0d_peak got ch=%0d amp=%0d want 0 0", v, peak_ch, peak_amp); end
`endif
      tick();
    end
  endtask

  task automatic test_drop;
    int cyc;
    bit seen;
    clear_frame();
    frame[100] = 16'd100; frame[101] = 16'd200; frame[102] = 16'd100;
    send_frame();
    pulse_locator(9'd100, 9'd102, 1'b1, 1'b0);
    repeat (10) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL drop_busy got %b want 1", busy); end
    data_in_valid = 1'b1;
    data_in_startofpacket = 1'b1;
    tick();
    data_in_valid = 1'b0;
    data_in_startofpacket = 1'b0;
    wait_result(100, cyc, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL drop_valid got none want pulse"); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("[TB] FAIL drop_cnt got %0d want 1", drop_cnt); end
    checks++; if (pos_data !== 16'h3280 || sum_data !== 32'd400) begin errors++; $display("[TB] FAIL drop_result got pos=%0d sum=%0d want 12928 400", pos_data, sum_data); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_accum;
    int cyc;
    bit seen;
    clear_frame();
    frame[50] = 16'd10;
    send_frame();
    pulse_locator(9'd0, 9'd200, 1'b1, 1'b0);
    repeat (5) tick();
    rst = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstacc_busy got %b want 0", busy); end
    checks++; if (pos_data !== 16'd0 || sum_data !== 32'd0) begin errors++; $display("[TB] FAIL rstacc_data got pos=%0d sum=%0d want 0 0", pos_data, sum_data); end
    checks++; if (drop_cnt !== 16'd0 || result_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstacc_misc got drop=%0d valid=%b want 0 0", drop_cnt, result_valid); end
    tick();
    rst = 1'b1;
    tick();
    clear_frame();
    frame[10] = 16'd100; frame[11] = 16'd300;
    send_frame();
    pulse_locator(9'd10, 9'd11, 1'b1, 1'b0);
    wait_result(100, cyc, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL rstacc_next_valid got none want pulse"); end
    checks++; if (pos_data !== 16'd1376 || sum_data !== 32'd400) begin errors++; $display("[TB] FAIL rstacc_next got pos=%0d sum=%0d want 1376 400", pos_data, sum_data); end
    tick();
  endtask

  task automatic test_timeout;
    int cyc;
    bit seen;
    clear_frame();
    frame[20] = 16'd55;
    send_frame();
    wait_result(1100, cyc, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL tmo_valid got none after %0d cycles want pulse", cyc); end
    checks++; if (cyc != 1024) begin errors++; $display("[TB] FAIL tmo_latency got %0d want 1024", cyc); end
    checks++; if (result_timeout !== 1'b1 || result_no_cluster !== 1'b0) begin errors++; $display("[TB] FAIL tmo_flags got to=%b nc=%b want 1 0", result_timeout, result_no_cluster); end
    checks++; if (pos_data !== 16'd0 || sum_data !== 32'd0) begin errors++; $display("[TB] FAIL tmo_data got pos=%0d sum=%0d want 0 0", pos_data, sum_data); end
    tick();
    pulse_locator(9'd20, 9'd20, 1'b1, 1'b0);
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_pulse_ignored got busy=%b valid=%b want 0 0", busy, result_valid); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst                   = 1'b0;
    data_in_data          = 16'h0000;
    data_in_valid         = 1'b0;
    data_in_startofpacket = 1'b0;
    data_in_endofpacket   = 1'b0;
    data_in_empty         = 2'b00;
    cl_ch_left            = 9'd0;
    cl_ch_right           = 9'd0;
    cl_has_cluster        = 1'b0;
    cl_no_cluster         = 1'b0;
    test_reset();
    test_centroid();
    test_no_cluster();
    test_drop();
    test_reset_mid_accum();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
